// File: rtl/spi_pkg.sv
// Shared types and constants for the mode-3 SPI slave endpoint.
package spi_pkg;

  typedef enum logic {IDLE, ACTIVE} spi_slv_state_t;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;

  // Position within the byte of the bit handled at a given bit count.
  function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] cnt,
                                                 input logic msb_first);
    return msb_first ? (CNT_W'(BYTE_W - 1) - cnt) : cnt;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizer chain plus history flop with one-cycle rise/fall detect pulses.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b1
) (
  input  logic clk,
  input  logic arstn,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      hist  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-3 slave: oversampled scl/cs/mosi, byte handshake to local logic.
// Optional flow control and sticky overrun flag under SPI_SLAVE_OVERRUN_EN.
module spi_slave_interface
  import spi_pkg::*;
#(
  parameter int CLK_FREC    = 100000000,
  parameter int SCL_FREC    = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic [BYTE_W-1:0] byte_2_send,
  output logic              tx_req,
  output logic [BYTE_W-1:0] byte_received,
  output logic              new_byte,
  output logic              end_trans,
  output logic              busy,
  input  logic              msb_lsb,
  input  logic              scl,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  input  logic              rx_ack,
  output logic              overrun
`endif
);

  if (SCL_FREC * 8 > CLK_FREC) begin : g_bad_freq
    $fatal(1, "spi_slave_interface: SCL_FREC*8 exceeds CLK_FREC");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $fatal(1, "spi_slave_interface: SYNC_STAGES must be 2 or 3");
  end

  logic unused_scl_sync;
  logic scl_rise, scl_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) u_scl_sync (
    .clk  (clk),
    .arstn(arstn),
    .din  (scl),
    .sync (unused_scl_sync),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk  (clk),
    .arstn(arstn),
    .din  (cs),
    .sync (cs_sync),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge clk) begin
    if (!arstn) mosi_chain <= '0;
    else        mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  spi_slv_state_t    state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_idx;
  logic [BYTE_W-1:0] tx_shift, tx_src;
  logic [BYTE_W-1:0] rx_shift, rx_next;
  logic              new_byte_q;
  logic              cs_fall_evt, cs_rise_evt, scl_fall_evt, scl_rise_evt;
  logic              byte_done;

  // cs rise wins over any scl edge seen in the same cycle.
  always_comb begin
    state_d      = state_q;
    cs_fall_evt  = 1'b0;
    cs_rise_evt  = 1'b0;
    scl_fall_evt = 1'b0;
    scl_rise_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          cs_fall_evt = 1'b1;
          state_d     = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          cs_rise_evt = 1'b1;
          state_d     = IDLE;
        end else begin
          scl_fall_evt = scl_fall;
          scl_rise_evt = scl_rise;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_idx          = bit_index(bit_cnt, msb_lsb);
    tx_src           = (bit_cnt == '0) ? byte_2_send : tx_shift;
    rx_next          = rx_shift;
    rx_next[bit_idx] = mosi_s;
    byte_done        = scl_rise_evt && (bit_cnt == CNT_W'(BYTE_W - 1));
  end

  // Handshake: tx_req asks for the next byte_2_send, which must stay stable
  // until the following new_byte/end_trans; new_byte qualifies byte_received.
  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_q       <= IDLE;
      bit_cnt       <= '0;
      tx_shift      <= '0;
      rx_shift      <= '0;
      byte_received <= '0;
      new_byte_q    <= 1'b0;
      tx_req        <= 1'b0;
      end_trans     <= 1'b0;
      miso          <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_req     <= 1'b0;
      new_byte_q <= 1'b0;
      end_trans  <= 1'b0;
      if (cs_fall_evt) begin
        tx_req  <= 1'b1;
        bit_cnt <= '0;
      end
      if (cs_rise_evt) begin
        end_trans <= 1'b1;
        miso      <= 1'b0;
      end
      if (scl_fall_evt) begin
        if (bit_cnt == '0) tx_shift <= byte_2_send;
        miso <= tx_src[bit_idx];
      end
      if (scl_rise_evt) begin
        rx_shift <= rx_next;
        bit_cnt  <= bit_cnt + CNT_W'(1);
      end
      if (byte_done) begin
        byte_received <= rx_next;
        new_byte_q    <= 1'b1;
        tx_req        <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_valid;

  always_ff @(posedge clk) begin
    if (!arstn) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (byte_done) begin
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
      if (cs_fall_evt) overrun <= 1'b0;
    end
  end

  assign new_byte = rx_valid;
`else
  assign new_byte = new_byte_q;
`endif

  assign busy    = ~cs_sync;
  assign miso_oe = busy;

endmodule

// File: tb/tb_spi_slave_interface.sv
// Directed bench: mode-3 master model, tx_req responder, scoreboard monitor.
module tb_spi_slave_interface;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic [7:0] byte_2_send = 8'h00;
  logic       msb_lsb = 1'b1;
  logic       scl = 1'b1;
  logic       cs = 1'b1;
  logic       mosi = 1'b0;
  logic       tx_req, new_byte, end_trans, busy, miso, miso_oe;
  logic [7:0] byte_received;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_ack = 1'b0;
  logic       overrun;
`endif

  spi_slave_interface dut (
    .clk          (clk),
    .arstn        (arstn),
    .byte_2_send  (byte_2_send),
    .tx_req       (tx_req),
    .byte_received(byte_received),
    .new_byte     (new_byte),
    .end_trans    (end_trans),
    .busy         (busy),
    .msb_lsb      (msb_lsb),
    .scl          (scl),
    .cs           (cs),
    .mosi         (mosi),
    .miso         (miso),
    .miso_oe      (miso_oe)
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    .rx_ack       (rx_ack),
    .overrun      (overrun)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] slv_q[$];
  int         end_cnt = 0;
  int         exp_end = 0;
  bit         auto_ack = 1'b1;
  logic       first_bit, last_bit;
  logic [7:0] rx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic check_idle_outputs(input string tag, input logic [7:0] exp_rx);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_new_byte"}, new_byte, 0);
    check({tag, "_end_trans"}, end_trans, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_miso"}, miso, 0);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_byte_received"}, byte_received, exp_rx);
  endtask

  task automatic xfer_begin();
    cs = 1'b0;
    wait_clk(HALF);
    @(negedge clk);
    check("busy_active", busy, 1);
    check("miso_oe_active", miso_oe, 1);
  endtask

  // Master drives mosi on scl fall, samples miso just before scl rise.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int b;
      b = msb_lsb ? 7 - i : i;
      @(negedge clk);
      scl  = 1'b0;
      mosi = tx[b];
      wait_clk(HALF);
      @(negedge clk);
      rxb[b] = miso;
      if (i == 0) first_bit = miso;
      last_bit = miso;
      scl = 1'b1;
      wait_clk(HALF);
    end
  endtask

  task automatic xfer_end();
    wait_clk(HALF);
    cs = 1'b1;
    wait_clk(20);
  endtask

  // tx_req responder
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req) byte_2_send = (slv_q.size() > 0) ? slv_q.pop_front() : 8'h00;
    end
  end

  // Monitor: pops the scoreboard whenever a byte is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (end_trans) end_cnt++;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_ack = 1'b0;
      if (new_byte && auto_ack) begin
        rx_ack = 1'b1;
`else
      if (new_byte) begin
`endif
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_new_byte: got %0h expected none", byte_received);
        end else begin
          check("byte_received", byte_received, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    wait_clk(4);
    @(negedge clk);
    check_idle_outputs("reset", 8'h00);
    arstn = 1'b1;
    wait_clk(10);

    // MSB first: 0xA5 in, 0x3C out
    msb_lsb = 1'b1;
    slv_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    xfer_begin();
    xfer_bits(8'hA5, 8, rx);
    xfer_end();
    exp_end++;
    check("t1_master_rx", rx, 8'h3C);
    check("t1_end_cnt", end_cnt, exp_end);
    check("t1_drained", exp_q.size(), 0);

    // LSB first: 0x01 in, 0x80 out
    msb_lsb = 1'b0;
    slv_q.push_back(8'h80);
    exp_q.push_back(8'h01);
    xfer_begin();
    xfer_bits(8'h01, 8, rx);
    xfer_end();
    exp_end++;
    check("t2_master_rx", rx, 8'h80);
    check("t2_first_bit", first_bit, 0);
    check("t2_last_bit", last_bit, 1);
    check("t2_end_cnt", end_cnt, exp_end);

    // three back-to-back bytes under one cs
    msb_lsb = 1'b1;
    slv_q.push_back(8'hAA); slv_q.push_back(8'hBB); slv_q.push_back(8'hCC);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    xfer_begin();
    xfer_bits(8'h11, 8, rx); check("t3_rx0", rx, 8'hAA);
    xfer_bits(8'h22, 8, rx); check("t3_rx1", rx, 8'hBB);
    xfer_bits(8'h33, 8, rx); check("t3_rx2", rx, 8'hCC);
    xfer_end();
    exp_end++;
    check("t3_end_cnt", end_cnt, exp_end);
    check("t3_drained", exp_q.size(), 0);

    // aborted byte after 4 bits, then a full 0x5A
    xfer_begin();
    xfer_bits(8'hF0, 4, rx);
    xfer_end();
    exp_end++;
    check("t4_held_rx", byte_received, 8'h33);
    check("t4_end_cnt", end_cnt, exp_end);
    slv_q.push_back(8'h69);
    exp_q.push_back(8'h5A);
    xfer_begin();
    xfer_bits(8'h5A, 8, rx);
    xfer_end();
    exp_end++;
    check("t4_master_rx", rx, 8'h69);
    check("t4_end_cnt2", end_cnt, exp_end);

    // reset for 2 cycles mid-byte, then 0xC3
    cs = 1'b0;
    wait_clk(HALF);
    xfer_bits(8'h77, 3, rx);
    @(negedge clk);
    arstn = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("midreset", 8'h00);
    cs  = 1'b1;
    scl = 1'b1;
    @(negedge clk);
    arstn = 1'b1;
    wait_clk(10);
    @(negedge clk);
    check_idle_outputs("postreset", 8'h00);
    check("t5_no_end", end_cnt, exp_end);
    slv_q.push_back(8'h96);
    exp_q.push_back(8'hC3);
    xfer_begin();
    xfer_bits(8'hC3, 8, rx);
    xfer_end();
    exp_end++;
    check("t5_master_rx", rx, 8'h96);
    check("t5_end_cnt", end_cnt, exp_end);

`ifdef SPI_SLAVE_OVERRUN_EN
    // two unacknowledged bytes raise overrun; next cs fall clears it
    auto_ack = 1'b0;
    xfer_begin();
    xfer_bits(8'h12, 8, rx);
    xfer_bits(8'h34, 8, rx);
    xfer_end();
    exp_end++;
    @(negedge clk);
    check("ovr_flag", overrun, 1);
    check("ovr_rx", byte_received, 8'h34);
    check("ovr_valid", new_byte, 1);
    cs = 1'b0;
    wait_clk(10);
    @(negedge clk);
    check("ovr_cleared", overrun, 0);
    cs = 1'b1;
    wait_clk(20);
    exp_end++;
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    auto_ack = 1'b1;
    check("ovr_end_cnt", end_cnt, exp_end);
`endif

    wait_clk(20);
    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_interface.md
Name: spi_slave_interface

Overview:
- SPI peripheral-side (slave) endpoint for mode 3 (CPOL=1, CPHA=1), the counterpart of the team's SPI master.
- Oversamples scl/cs/mosi in the system clock domain, shifts mosi in on scl rising edges and drives miso on scl falling edges.
- Presents whole bytes to local logic with a byte-level handshake.
- Full-duplex, 8-bit frames, back-to-back bytes while cs stays low.

Parameters:
- CLK_FREC, 100000000, system clock frequency in Hz.
- SCL_FREC, 1000000, maximum supported scl frequency in Hz. Elaboration-time $fatal if SCL_FREC*8 > CLK_FREC.
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input. Legal values are 2 or 3.

Ports:
- clk  in  1  system clock.
- arstn  in  1  reset. Synchronous, active-low.
- byte_2_send  in  8  next byte to shift out on miso. Sampled at the first scl falling edge of each byte.
- tx_req  out  1  1-cycle pulse requesting a new byte_2_send value. Hold byte_2_send stable from tx_req until the next new_byte or end_trans.
- byte_received  out  8  last complete byte from mosi. Valid while new_byte=1 and held afterwards.
- new_byte  out  1  1-cycle pulse when a full byte has been received.
- end_trans  out  1  1-cycle pulse when cs deasserts.
- busy  out  1  1 while synchronized cs is low.
- msb_lsb  in  1  bit order: 1 = MSB first, 0 = LSB first. Static during a transaction.
- scl  in  1  SPI clock from the master. Idles high.
- cs  in  1  chip select, active low.
- mosi  in  1  master data in.
- miso  out  1  slave data out.
- miso_oe  out  1  output enable for an external tristate. Equals busy.

Behaviour:
- Reset, while arstn=0 at a clk edge:
  - All outputs are 0, except miso_oe=0 and busy=0.
  - Synchronizers are preset to their idle values (scl=1, cs=1, mosi=0).
  - bit_cnt=0, shift registers=0, FSM=IDLE.
- Input conditioning:
  - scl and cs pass through SYNC_STAGES flops plus one history flop.
  - rise/fall detect pulses are 1 cycle wide.
  - mosi passes through SYNC_STAGES flops only.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on cs fall detect. In the same cycle: tx_req pulses and bit_cnt=0.
  - ACTIVE -> IDLE on cs rise detect. end_trans pulses and miso returns to 0.
  - An incomplete byte is discarded: no new_byte, and byte_received is unchanged.
- In ACTIVE, on scl fall detect:
  - If bit_cnt=0, latch byte_2_send into tx_shift.
  - Then drive miso = tx_shift bit at index (msb_lsb ? 7-bit_cnt : bit_cnt) on the next clk.
  - For bit_cnt=0, drive directly from byte_2_send.
  - Latency from the scl pin falling to miso changing is at most SYNC_STAGES+2 clk.
- In ACTIVE, on scl rise detect:
  - Store synchronized mosi into rx_shift at index (msb_lsb ? 7-bit_cnt : bit_cnt).
  - bit_cnt increments.
  - When bit_cnt was 7: bit_cnt wraps to 0, byte_received <= the completed rx byte (including this bit), and new_byte plus tx_req pulse on the next cycle.
- Simultaneous events:
  - cs rise detect takes priority over an scl edge in the same cycle; the edge is ignored.
  - An scl edge in IDLE is ignored.
- bit_cnt is 3 bits wide and wraps modulo 8.
- miso holds its last value between falling edges. miso=0 in IDLE.
- Reset mid-transfer forces IDLE immediately; the master's byte is lost. After reset, a new cs fall is required before the block reacts.

Optional Feature:
- Macro: SPI_SLAVE_OVERRUN_EN.
- When defined:
  - Adds input rx_ack (1) and output overrun (1).
  - byte_received stays valid (rx_valid level) until rx_ack=1.
  - A new byte completing while still unacknowledged sets sticky overrun and overwrites byte_received.
  - overrun clears only on reset or cs fall detect.
- When undefined: no extra ports, and new_byte remains a 1-cycle pulse with no flow control.

Decomposition:
- Package spi_pkg holds:
  - typedef enum logic {IDLE, ACTIVE} spi_slv_state_t.
  - localparam BYTE_W=8 and bit-counter width $clog2(BYTE_W).
  - SPI mode constants CPOL=1 and CPHA=1.
- Sub-module spi_sync_edge: synchronizer chain + history flop. Parameters SYNC_STAGES and RESET_VAL; outputs sync, rise, fall. Instantiated for scl (RESET_VAL=1) and cs (RESET_VAL=1).

Test Plan:
- Mode-3 master model at 1 MHz, MSB first; master sends 0xA5 while slave byte_2_send=0x3C -> byte_received=0xA5 with one new_byte pulse; master captures 0x3C; end_trans pulses once after cs rises.
- msb_lsb=0; master sends 0x01 and slave sends 0x80 -> byte_received=0x01; first miso bit is 0 and last is 1.
- Three back-to-back bytes 0x11, 0x22, 0x33 under one cs, with slave answering 0xAA, 0xBB, 0xCC loaded on each tx_req -> three new_byte pulses in order; master reads 0xAA, 0xBB, 0xCC.
- cs raised after 4 scl rising edges -> no new_byte; byte_received keeps its previous value; end_trans pulses. Next full transfer of 0x5A -> byte_received=0x5A.
- arstn=0 for 2 cycles mid-byte -> all outputs 0. The subsequent cs-framed 0xC3 is received correctly.
- With SPI_SLAVE_OVERRUN_EN, two bytes sent without rx_ack -> overrun=1 and byte_received holds the second byte. cs fall -> overrun=0.
